bpnet_core: RTL and testbench
=============================

BPNET_CORE -- requirements
Module: bpnet_core

Interface
REQ-001 SHALL have parameter N_IN, default 9, number of input elements.
REQ-002 SHALL have parameter IN_W, default 8, unsigned input element width.
REQ-003 SHALL have parameter N_HID, default 4, hidden neuron count.
REQ-004 SHALL have parameter N_OUT, default 1, output neuron count.
REQ-005 SHALL have parameter W_W, default 16, signed weight/bias width.
REQ-006 SHALL have parameter FRAC, default 8, fractional bits of weights.
REQ-007 SHALL have parameter ACC_W, default 32, signed accumulator width.
REQ-008 SHALL have parameter D_W, default 16, signed hidden/result width.
REQ-009 SHALL have parameter ADDR_W, default 6, parameter-ROM address width.
REQ-010 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; rst_n  in  1  async reset, active low.
REQ-011 SHALL have ports: start  in  1  request a run; x  in  N_IN*IN_W  input vector, element i at bits [i*IN_W +: IN_W].
REQ-012 SHALL have ports: rom_addr  out  ADDR_W  ROM read address; rom_data  in  W_W  ROM word, valid one cycle after its address.
REQ-013 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle completion pulse; result  out  N_OUT*D_W  outputs, k at [k*D_W +: D_W]; sat  out  1  saturation occurred in last run.

Function
REQ-014 SHALL implement states IDLE, L1, L2, DONE; busy=1 in L1 and L2 only.
REQ-015 SHALL accept start only in IDLE; acceptance captures x into an internal register, clears sat and enters L1.
REQ-016 SHALL ignore start in L1, L2 and DONE; start held high SHALL cause a new run on the cycle after DONE.
REQ-017 SHALL lay out the ROM as: layer-1 neuron j weight i at j*(N_IN+1)+i, its bias at j*(N_IN+1)+N_IN; layer-2 base B2=N_HID*(N_IN+1), neuron k weight j at B2+k*(N_HID+1)+j, its bias at B2+k*(N_HID+1)+N_HID.
REQ-018 SHALL compute each neuron serially in exactly fan_in+2 cycles (fan_in+1 address cycles, then one store cycle), one multiply-accumulate per cycle.
REQ-019 SHALL compute acc = sum(input*weight) + (bias sign-extended), in ACC_W two's-complement with modular wrap.
REQ-020 SHALL treat layer-1 inputs as zero-extended unsigned x elements and layer-2 inputs as the stored hidden values.
REQ-021 SHALL form each neuron output as acc arithmetically shifted right by FRAC, saturated to signed D_W range.
REQ-022 SHALL apply ReLU (negative -> 0) after saturation to layer-1 outputs only; layer-2 outputs are signed.
REQ-023 SHALL set sat when any neuron in the run saturates; sat is held until the next accepted start.
REQ-024 SHALL transition L1->L2 after the store of hidden neuron N_HID-1, and L2->DONE after the store of output N_OUT-1.
REQ-025 SHALL update result with all N_OUT outputs simultaneously, on entry to DONE; result holds between runs.
REQ-026 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-027 SHALL give latency L = N_HID*(N_IN+2) + N_OUT*(N_HID+2) + 1 cycles from the accepting edge to done high (51 at defaults).
REQ-028 SHALL drive rom_addr to 0 in IDLE and DONE.

Reset
REQ-029 SHALL on rst_n low, at any time, force IDLE and clear busy, done, sat, result, rom_addr, accumulator and hidden registers to 0.
REQ-030 SHALL on reset mid-run abandon the run with no done pulse and no result update.

Verification
REQ-031 Reset: rst_n low -> busy=0, done=0, sat=0, result=0, rom_addr=0.
REQ-032 All weights 0, layer-2 bias 1280, start -> done exactly 51 cycles later, result=5, sat=0.
REQ-033 x all 1, every weight 256, all biases 0 -> hidden=9 each, result=36, sat=0.
REQ-034 x all 255, layer-1 weights 32767 -> hidden=32767, sat=1; with layer-2 weights 0 and bias 0 -> result=0, sat stays 1.
REQ-035 Layer-1 weights -256, x all 1 -> hidden=0 via ReLU, result=layer-2 bias>>8.
REQ-036 Start pulsed during busy -> ignored, single done at cycle 51; rst_n low at cycle 20 -> no done, result=0.

Source files
------------

// File: rtl/bpnet_core.sv
// bpnet_core: two-layer fixed-point perceptron evaluated one multiply-accumulate
// per clock. Weights and biases are streamed from an external parameter ROM.
// The hidden layer uses ReLU. The output layer is linear and signed.
//
// Ports
//   clk       clock
//   rst_n     asynchronous reset, active low
//   start     request a run (accepted only while idle)
//   x         N_IN unsigned elements, element i at [i*IN_W +: IN_W]
//   rom_addr  parameter-ROM read address (0 while idle / done)
//   rom_data  ROM word, valid one cycle after its address
//   busy      high while either layer is being evaluated
//   done      one-cycle completion pulse
//   result    N_OUT signed outputs, output k at [k*D_W +: D_W]
//   sat       some neuron saturated during the last run
module bpnet_core #(
    parameter int N_IN   = 9,
    parameter int IN_W   = 8,
    parameter int N_HID  = 4,
    parameter int N_OUT  = 1,
    parameter int W_W    = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 32,
    parameter int D_W    = 16,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N_IN*IN_W-1:0]  x,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [W_W-1:0]        rom_data,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT*D_W-1:0]  result,
    output logic                  sat
);

    localparam int MAX_FAN = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int CNT_W   = $clog2(MAX_FAN + 2);
    localparam int MAX_NRN = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int NRN_W   = $clog2(MAX_NRN) + 1;
    localparam int OP_W    = (IN_W + 1 > D_W) ? IN_W + 1 : D_W;
    localparam int PROD_W  = OP_W + W_W;

    localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] DMIN = {{(ACC_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t state_q, state_d;

    logic        [IN_W-1:0]   x_p0 [N_IN];
    logic        [CNT_W-1:0]  idx_p0;
    logic        [NRN_W-1:0]  nrn_p0;
    logic        [ADDR_W-1:0] ptr_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [D_W-1:0]    hid_p2 [N_HID];
    logic signed [D_W-1:0]    out_p2 [N_OUT];
    logic                     sat_p2;

    logic                     lay1, run, accept, store, mac, last_nrn;
    int                       fan;
    logic signed [OP_W-1:0]   op_p1;
    logic signed [W_W-1:0]    w_p1;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]  fin_p1;
    logic signed [D_W-1:0]    nv_p2;
    logic                     ovf_p2;

    // Scale the accumulator down by FRAC and report whether it leaves D_W range.
    function automatic logic ovf_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        return (sh > DMAX) || (sh < DMIN);
    endfunction

    function automatic logic signed [D_W-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC;
        if (sh > DMAX)
            return {1'b0, {(D_W-1){1'b1}}};
        else if (sh < DMIN)
            return {1'b1, {(D_W-1){1'b0}}};
        else
            return sh[D_W-1:0];
    endfunction

    // ---- control: sequencing of neurons and layers ----
    always_comb begin
        lay1     = (state_q == L1);
        run      = (state_q == L1) || (state_q == L2);
        accept   = (state_q == IDLE) && start;
        fan      = lay1 ? N_IN : N_HID;
        // Each neuron: fan+1 address cycles (idx 0..fan), then a store cycle (idx fan+1).
        store    = run && (int'(idx_p0) == fan + 1);
        mac      = run && (idx_p0 != '0) && !store;
        last_nrn = (int'(nrn_p0) == (lay1 ? N_HID : N_OUT) - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        rom_addr = '0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = L1;
            end
            L1: begin
                busy     = 1'b1;
                rom_addr = ptr_p0;
                if (store && last_nrn)
                    state_d = L2;
            end
            L2: begin
                busy     = 1'b1;
                rom_addr = ptr_p0;
                if (store && last_nrn)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p1: operand select, multiply, final sum with bias ----
    // The ROM word seen in cycle idx belongs to the address issued in cycle idx-1,
    // so input element idx-1 pairs with it.
    always_comb begin
        op_p1 = '0;
        for (int i = 0; i < N_IN; i++)
            if (lay1 && (i == int'(idx_p0) - 1))
                op_p1 = {{(OP_W-IN_W){1'b0}}, x_p0[i]};
        for (int j = 0; j < N_HID; j++)
            if (!lay1 && (j == int'(idx_p0) - 1))
                op_p1 = OP_W'(hid_p2[j]);
        w_p1    = rom_data;
        prod_p1 = PROD_W'(op_p1) * PROD_W'(w_p1);
        // In the store cycle the ROM word is the bias.
        fin_p1  = acc_p1 + ACC_W'(w_p1);
    end

    // ---- stage p2: scale, saturate, ReLU on the hidden layer ----
    always_comb begin
        ovf_p2 = ovf_fn(fin_p1);
        nv_p2  = sat_fn(fin_p1);
        if (lay1 && nv_p2[D_W-1])
            nv_p2 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++)
                x_p0[i] <= '0;
            idx_p0 <= '0;
            nrn_p0 <= '0;
            ptr_p0 <= '0;
            acc_p1 <= '0;
            for (int j = 0; j < N_HID; j++)
                hid_p2[j] <= '0;
            for (int k = 0; k < N_OUT; k++)
                out_p2[k] <= '0;
            sat_p2 <= 1'b0;
            result <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_IN; i++)
                x_p0[i] <= x[i*IN_W +: IN_W];
            idx_p0 <= '0;
            nrn_p0 <= '0;
            ptr_p0 <= '0;
            acc_p1 <= '0;
            sat_p2 <= 1'b0;
        end else if (run) begin
            if (store) begin
                idx_p0 <= '0;
                acc_p1 <= '0;
                sat_p2 <= sat_p2 | ovf_p2;
                nrn_p0 <= last_nrn ? '0 : nrn_p0 + NRN_W'(1);
                if (lay1) begin
                    for (int j = 0; j < N_HID; j++)
                        if (j == int'(nrn_p0))
                            hid_p2[j] <= nv_p2;
                end else begin
                    for (int k = 0; k < N_OUT; k++)
                        if (k == int'(nrn_p0))
                            out_p2[k] <= nv_p2;
                    // All outputs appear together when the last one is finished.
                    if (last_nrn)
                        for (int k = 0; k < N_OUT; k++)
                            result[k*D_W +: D_W] <= (k == int'(nrn_p0)) ? nv_p2 : out_p2[k];
                end
            end else begin
                // Layout is contiguous, so the pointer simply walks the ROM;
                // it holds during store cycles and lands on the next neuron's base.
                idx_p0 <= idx_p0 + CNT_W'(1);
                ptr_p0 <= ptr_p0 + ADDR_W'(1);
                if (mac)
                    acc_p1 <= acc_p1 + ACC_W'(prod_p1);
            end
        end
    end

    assign sat = sat_p2;

endmodule

// File: tb/tb_bpnet_core.sv
module tb_bpnet_core;

    localparam int N_IN = 9, IN_W = 8, N_HID = 4, N_OUT = 1;
    localparam int W_W = 16, FRAC = 8, ACC_W = 32, D_W = 16, ADDR_W = 6;
    localparam int B2  = N_HID * (N_IN + 1);
    localparam int LAT = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + 1;

    logic                  clk, rst_n, start;
    logic [N_IN*IN_W-1:0]  x;
    logic [ADDR_W-1:0]     rom_addr;
    logic [W_W-1:0]        rom_data;
    logic                  busy, done, sat;
    logic [N_OUT*D_W-1:0]  result;

    logic signed [W_W-1:0] rom [64];

    int checks = 0;
    int errors = 0;

    bpnet_core #(
        .N_IN(N_IN), .IN_W(IN_W), .N_HID(N_HID), .N_OUT(N_OUT), .W_W(W_W),
        .FRAC(FRAC), .ACC_W(ACC_W), .D_W(D_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .done(done), .result(result), .sat(sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read parameter ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic               s;
        logic signed [63:0] r;
    } mres_t;

    function automatic longint scale(input longint acc, inout logic s);
        longint v;
        v = longint'(int'(acc)) >>> FRAC;   // 32-bit modular accumulator
        if (v > 32767) begin
            s = 1'b1;
            v = 32767;
        end else if (v < -32768) begin
            s = 1'b1;
            v = -32768;
        end
        return v;
    endfunction

    function automatic mres_t model_run(input logic [N_IN*IN_W-1:0] xv);
        mres_t  m;
        longint h [N_HID];
        longint acc;
        logic   s;
        s = 1'b0;
        for (int j = 0; j < N_HID; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'(xv[i*IN_W +: IN_W]) * longint'(rom[j*(N_IN+1)+i]);
            acc += longint'(rom[j*(N_IN+1)+N_IN]);
            h[j] = scale(acc, s);
            if (h[j] < 0) h[j] = 0;
        end
        acc = 0;
        for (int j = 0; j < N_HID; j++)
            acc += h[j] * longint'(rom[B2+j]);
        acc += longint'(rom[B2+N_HID]);
        m.r = scale(acc, s);
        m.s = s;
        return m;
    endfunction

    function automatic int exp_addr(input int c);
        int c1, c2;
        if (c <= 0 || c >= LAT) return 0;
        c1 = c - 1;
        if (c1 < N_HID*(N_IN+2)) begin
            if (c1 % (N_IN+2) <= N_IN) return (c1/(N_IN+2))*(N_IN+1) + c1 % (N_IN+2);
            return -1;
        end
        c2 = c1 - N_HID*(N_IN+2);
        if (c2 % (N_HID+2) <= N_HID) return B2 + (c2/(N_HID+2))*(N_HID+1) + c2 % (N_HID+2);
        return -1;
    endfunction

    // m_cnt: 0 = idle, 1..LAT-1 = cycle of the run, LAT = completion cycle.
    int     m_cnt = 0;
    longint m_res = 0;
    logic   m_sat = 1'b0;
    mres_t  p_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_res <= 0;
            m_sat <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= 1;
                p_run <= model_run(x);
            end
        end else if (m_cnt == LAT) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) begin
                m_res <= p_run.r;
                m_sat <= p_run.s;
            end
        end
    end

    always @(negedge clk) begin
        int ea;
        chk("busy", busy, (m_cnt > 0 && m_cnt < LAT));
        chk("done", done, (m_cnt == LAT));
        ea = exp_addr(m_cnt);
        if (ea >= 0) chk("rom_addr", rom_addr, ea);
        if (m_cnt == 0 || m_cnt == LAT) begin
            chk("result", longint'($signed(result)), m_res);
            chk("sat", sat, m_sat);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [N_IN*IN_W-1:0] xfill(input int v);
        logic [N_IN*IN_W-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*IN_W +: IN_W] = IN_W'(v);
        return r;
    endfunction

    task automatic set_rom(input int l1w, input int l1b, input int l2w, input int l2b);
        for (int a = 0; a < 64; a++) rom[a] = '0;
        for (int j = 0; j < N_HID; j++) begin
            for (int i = 0; i < N_IN; i++) rom[j*(N_IN+1)+i] = W_W'(l1w);
            rom[j*(N_IN+1)+N_IN] = W_W'(l1b);
        end
        for (int j = 0; j < N_HID; j++) rom[B2+j] = W_W'(l2w);
        rom[B2+N_HID] = W_W'(l2b);
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (busy || done) @(negedge clk);
    endtask

    task automatic run_one(input string tag, input logic [N_IN*IN_W-1:0] xv,
                           input longint exp_res, input logic exp_sat);
        int c;
        wait_idle();
        x = xv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            @(posedge clk);
            #1 c++;
        end
        chk({tag, "_latency"}, c, LAT);
        chk({tag, "_result"}, longint'($signed(result)), exp_res);
        chk({tag, "_sat"}, sat, exp_sat);
    endtask

    initial begin
        int c, nd, first, second;
        rst_n = 1'b1;
        start = 1'b0;
        x     = '0;
        set_rom(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_result", result, 0);
        chk("rst_addr", rom_addr, 0);
        @(negedge clk) rst_n = 1'b1;

        set_rom(0, 0, 0, 1280);           run_one("bias_only", 72'h0102030405060708FF, 5, 0);
        set_rom(256, 0, 256, 0);          run_one("unity", xfill(1), 36, 0);
        set_rom(32767, 0, 0, 0);          run_one("hid_sat", xfill(255), 0, 1);
        set_rom(-256, 0, 256, 2560);      run_one("relu", xfill(1), 10, 0);
        set_rom(256, 0, -256, 0);         run_one("neg_out", xfill(1), -36, 0);
        set_rom(32767, 0, -32768, 0);     run_one("acc_wrap", xfill(255), 512, 1);
        set_rom(256, 0, -32768, 0);       run_one("out_negsat", xfill(255), -32768, 1);
        set_rom(0, 2560, 256, -512);      run_one("l1_bias", xfill(7), 38, 0);
        set_rom(0, 0, 0, -1);             run_one("asr_floor", xfill(3), -1, 0);

        // start pulsed mid-run with a different x: ignored, x stays captured
        set_rom(256, 0, 256, 0);
        wait_idle();
        x = xfill(1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 1;
        while (!done && c < 200) begin
            @(posedge clk);
            #1 c++;
            if (c == 10) begin start = 1'b1; x = xfill(2); end
            if (c == 11) start = 1'b0;
        end
        chk("ignore_latency", c, LAT);
        chk("ignore_result", longint'($signed(result)), 36);
        nd = 0;
        repeat (70) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        chk("ignore_no_rerun", nd, 0);

        // start held high: second run begins the cycle after DONE
        wait_idle();
        x = xfill(1);
        start = 1'b1;
        @(posedge clk);
        c = 1; nd = 0; first = 0; second = 0;
        #1;
        while (nd < 2 && c < 300) begin
            @(posedge clk);
            #1 c++;
            if (done) begin
                nd++;
                if (nd == 1) first = c; else begin second = c; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("held_first", first, LAT);
        chk("held_second", second, 2*LAT + 1);
        chk("held_result", longint'($signed(result)), 36);

        // reset in the middle of a run that has already saturated
        set_rom(32767, 0, -32768, 0);
        wait_idle();
        x = xfill(255);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 1;
        while (c < 20) begin
            @(posedge clk);
            #1 c++;
        end
        chk("pre_rst_sat", sat, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sat", sat, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_addr", rom_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (80) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        chk("mid_rst_no_done", nd, 0);
        chk("mid_rst_result_hold", result, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
